// File: rtl/seg2bcd_scanner_if.sv
// Bus between a multiplexed 7-segment display and seg2bcd_scanner:
// scanned segment/select pins in, decoded frame out.
interface seg2bcd_scanner_if #(
  parameter int N_DIGITS = 4
);
  logic [7:0]            segments_in;
  logic [N_DIGITS-1:0]   digit_sel;
  logic [4*N_DIGITS-1:0] bcd_out;
  logic [N_DIGITS-1:0]   dp_out;
  logic [N_DIGITS-1:0]   blank_out;
  logic [N_DIGITS-1:0]   err_out;
  logic                  frame_valid;

  modport master (
    output segments_in, digit_sel,
    input  bcd_out, dp_out, blank_out, err_out, frame_valid
  );

  modport slave (
    input  segments_in, digit_sel,
    output bcd_out, dp_out, blank_out, err_out, frame_valid
  );
endinterface

// File: rtl/seg2bcd_scanner.sv
// Recovers a BCD frame from a scanned, multiplexed 7-segment display bus.
// Optional: define SEG2BCD_ALT_GLYPH_EN to accept alternate 6/7/9 glyphs.
module seg2bcd_scanner #(
  parameter logic COMMON_ANODE  = 1'b1,
  parameter int   N_DIGITS      = 4,
  parameter int   SETTLE_CYCLES = 8
) (
  input logic              clk,
  input logic              rst,
  seg2bcd_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SETTLE_FULL = 8'(SETTLE_CYCLES);

  // Returns {err, blank, bcd} for an active-high a..g pattern (MSB = a).
  function automatic logic [5:0] decode_glyph(input logic [6:0] abcdefg);
    logic [5:0] r;
    r = {2'b10, 4'hE};
    case (abcdefg)
      7'b1111110: r = {2'b00, 4'd0};
      7'b0110000: r = {2'b00, 4'd1};
      7'b1101101: r = {2'b00, 4'd2};
      7'b1111001: r = {2'b00, 4'd3};
      7'b0110011: r = {2'b00, 4'd4};
      7'b1011011: r = {2'b00, 4'd5};
      7'b1011111: r = {2'b00, 4'd6};
      7'b1110000: r = {2'b00, 4'd7};
      7'b1111111: r = {2'b00, 4'd8};
      7'b1111011: r = {2'b00, 4'd9};
      7'b0000000: r = {2'b01, 4'hF};
`ifdef SEG2BCD_ALT_GLYPH_EN
      7'b0011111: r = {2'b00, 4'd6};
      7'b1110010: r = {2'b00, 4'd7};
      7'b1110011: r = {2'b00, 4'd9};
`endif
      default:    r = {2'b10, 4'hE};
    endcase
    return r;
  endfunction

  // Stage p0: pin registers; p1 keeps the previous sample for the settle compare
  logic [7:0]          seg_p0, seg_p1;
  logic [N_DIGITS-1:0] sel_p0, sel_p1;

  always_ff @(posedge clk) begin
    seg_p0 <= bus.segments_in;
    sel_p0 <= bus.digit_sel;
    seg_p1 <= seg_p0;
    sel_p1 <= sel_p0;
  end

  logic [7:0] seg_norm;
  logic       sel_onehot;
  logic       sample_same;
  logic [5:0] glyph;

  assign seg_norm    = COMMON_ANODE ? ~seg_p0 : seg_p0;
  assign sel_onehot  = $onehot(sel_p0);
  assign sample_same = (seg_p0 == seg_p1) && (sel_p0 == sel_p1);
  assign glyph       = decode_glyph(seg_norm[7:1]);

  state_t     state, state_n;
  logic [7:0] settle_cnt, settle_cnt_n;
  logic       cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
    end
  end

  // A changed sample restarts settling on that same cycle, so every value
  // sees the same capture latency no matter which state it arrives in.
  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    cap          = 1'b0;
    if (!sel_onehot) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          settle_cnt_n = 8'd1;
          state_n      = SETTLE;
        end
        SETTLE: begin
          if (!sample_same) begin
            settle_cnt_n = 8'd1;
          end else if (settle_cnt == SETTLE_LAST) begin
            cap          = 1'b1;
            settle_cnt_n = SETTLE_FULL;
            state_n      = HOLD;
          end else begin
            settle_cnt_n = settle_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (!sample_same) begin
            settle_cnt_n = 8'd1;
            state_n      = SETTLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stage p2: shadow slots and seen mask
  logic [N_DIGITS-1:0]   seen_mask, seen_next;
  logic                  vld_p2;
  logic [4*N_DIGITS-1:0] sh_bcd;
  logic [N_DIGITS-1:0]   sh_dp, sh_blank, sh_err;

  assign seen_next = seen_mask | sel_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_mask <= '0;
      vld_p2    <= 1'b0;
      sh_bcd    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_err    <= '0;
    end else begin
      vld_p2 <= 1'b0;
      if (cap) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (sel_p0[i]) begin
            sh_bcd[4*i +: 4] <= glyph[3:0];
            sh_blank[i]      <= glyph[4];
            sh_err[i]        <= glyph[5];
            sh_dp[i]         <= seg_norm[0];
          end
        end
        if (&seen_next) begin
          seen_mask <= '0;
          vld_p2    <= 1'b1;
        end else begin
          seen_mask <= seen_next;
        end
      end
    end
  end

  // Stage p3: published frame
  logic [4*N_DIGITS-1:0] bcd_p3;
  logic [N_DIGITS-1:0]   dp_p3, blank_p3, err_p3;
  logic                  vld_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_p3   <= '0;
      dp_p3    <= '0;
      blank_p3 <= '0;
      err_p3   <= '0;
      vld_p3   <= 1'b0;
    end else begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        bcd_p3   <= sh_bcd;
        dp_p3    <= sh_dp;
        blank_p3 <= sh_blank;
        err_p3   <= sh_err;
      end
    end
  end

  assign bus.bcd_out     = bcd_p3;
  assign bus.dp_out      = dp_p3;
  assign bus.blank_out   = blank_p3;
  assign bus.err_out     = err_p3;
  assign bus.frame_valid = vld_p3;

endmodule

// File: tb/tb_seg2bcd_scanner.sv
// Bench for seg2bcd_scanner: one common-anode and one common-cathode instance
// fed the same logical stimulus, checked against a run-length frame model.
module tb_seg2bcd_scanner;

  localparam int S = 8;

  // Logical (active-high) patterns {a,b,c,d,e,f,g,dp}
  localparam logic [7:0] P0 = 8'b11111100;
  localparam logic [7:0] P1 = 8'b01100000;
  localparam logic [7:0] P2 = 8'b11011010;
  localparam logic [7:0] P3 = 8'b11110010;
  localparam logic [7:0] P4 = 8'b01100110;
  localparam logic [7:0] P5 = 8'b10110110;
  localparam logic [7:0] P6 = 8'b10111110;
  localparam logic [7:0] P7 = 8'b11100000;
  localparam logic [7:0] P8 = 8'b11111110;
  localparam logic [7:0] P9 = 8'b11110110;
  localparam logic [7:0] PBLANK = 8'b00000000;
  localparam logic [7:0] PBAD   = 8'b10000010;
  localparam logic [7:0] A6 = 8'b00111110;
  localparam logic [7:0] A7 = 8'b11100100;
  localparam logic [7:0] A9 = 8'b11100110;

  localparam logic [6:0] GLYPH [10] = '{7'b1111110, 7'b0110000, 7'b1101101,
    7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] drv_sel = 4'b0000;
  logic [7:0] drv_pat = 8'h00;

  always #5 clk = ~clk;

  seg2bcd_scanner_if #(.N_DIGITS(4)) if_ca ();
  seg2bcd_scanner_if #(.N_DIGITS(4)) if_cc ();

  assign if_ca.digit_sel   = drv_sel;
  assign if_ca.segments_in = ~drv_pat;
  assign if_cc.digit_sel   = drv_sel;
  assign if_cc.segments_in = drv_pat;

  seg2bcd_scanner #(.COMMON_ANODE(1'b1), .N_DIGITS(4), .SETTLE_CYCLES(S)) u_ca (
    .clk(clk), .rst(rst), .bus(if_ca.slave));
  seg2bcd_scanner #(.COMMON_ANODE(1'b0), .N_DIGITS(4), .SETTLE_CYCLES(S)) u_cc (
    .clk(clk), .rst(rst), .bus(if_cc.slave));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  int fv_edge = -1;
  int printed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a sample unchanged for S+1 consecutive edges (counting from a
  // change or from reset) is captured once; a full set publishes next edge.
  function automatic logic [5:0] model_decode(input logic [6:0] g);
    for (int i = 0; i < 10; i++)
      if (g == GLYPH[i]) return {2'b00, 4'(i)};
`ifdef SEG2BCD_ALT_GLYPH_EN
    if (g == 7'b0011111) return {2'b00, 4'd6};
    if (g == 7'b1110010) return {2'b00, 4'd7};
    if (g == 7'b1110011) return {2'b00, 4'd9};
`endif
    if (g == 7'b0000000) return {2'b01, 4'hF};
    return {2'b10, 4'hE};
  endfunction

  logic [11:0] m_prev = '0;
  int          m_run = 0;
  logic [15:0] m_sh_bcd = '0;
  logic [3:0]  m_sh_dp = '0, m_sh_blank = '0, m_sh_err = '0, m_mask = '0;
  logic        m_pend = 1'b0;
  logic [15:0] e_bcd = '0;
  logic [3:0]  e_dp = '0, e_blank = '0, e_err = '0;
  logic        e_fv = 1'b0;

  always @(posedge clk) begin
    logic [11:0] cur;
    logic [5:0]  dec;
    cyc++;
    cur = {drv_sel, drv_pat};
    if (cur == m_prev) begin
      if (m_run < 100000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = cur;
    if (rst) begin
      m_run = 1;
      m_pend = 1'b0; m_mask = '0; e_fv = 1'b0;
      m_sh_bcd = '0; m_sh_dp = '0; m_sh_blank = '0; m_sh_err = '0;
      e_bcd = '0; e_dp = '0; e_blank = '0; e_err = '0;
    end else begin
      e_fv = m_pend;
      if (m_pend) begin
        e_bcd = m_sh_bcd; e_dp = m_sh_dp; e_blank = m_sh_blank; e_err = m_sh_err;
      end
      m_pend = 1'b0;
      if (m_run == S + 1 && $onehot(drv_sel)) begin
        dec = model_decode(drv_pat[7:1]);
        for (int i = 0; i < 4; i++) begin
          if (drv_sel[i]) begin
            m_sh_bcd[4*i +: 4] = dec[3:0];
            m_sh_blank[i] = dec[4];
            m_sh_err[i] = dec[5];
            m_sh_dp[i] = drv_pat[0];
          end
        end
        m_mask = m_mask | drv_sel;
        if (m_mask == 4'hF) begin
          m_pend = 1'b1;
          m_mask = '0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    logic [28:0] exp_v, got_a, got_c;
    if (chk_en) begin
      exp_v = {e_bcd, e_dp, e_blank, e_err, e_fv};
      got_a = {if_ca.bcd_out, if_ca.dp_out, if_ca.blank_out, if_ca.err_out, if_ca.frame_valid};
      got_c = {if_cc.bcd_out, if_cc.dp_out, if_cc.blank_out, if_cc.err_out, if_cc.frame_valid};
      tests += 2;
      if (got_a !== exp_v) begin
        fails++;
        if (printed < 20) $display("FAIL model_ca cyc %0d: got 0x%0h expected 0x%0h", cyc, got_a, exp_v);
        printed++;
      end
      if (got_c !== exp_v) begin
        fails++;
        if (printed < 20) $display("FAIL model_cc cyc %0d: got 0x%0h expected 0x%0h", cyc, got_c, exp_v);
        printed++;
      end
      if (if_ca.frame_valid) begin
        pulses++;
        fv_edge = cyc;
      end
    end
  end

  task automatic hold(input logic [3:0] sel, input logic [7:0] pat, input int n);
    drv_sel = sel;
    drv_pat = pat;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    int p0;
    @(negedge clk);
    chk_en = 1'b1;
    hold(4'b0000, 8'h00, 2);
    check("reset_bcd", 32'(if_ca.bcd_out), 32'h0);
    check("reset_flags", 32'({if_ca.dp_out, if_ca.blank_out, if_ca.err_out, if_ca.frame_valid}), 32'h0);
    rst = 1'b0;
    hold(4'b0000, 8'h00, 3);

    // Full frame 1,2,3,4
    p0 = pulses;
    hold(4'b0001, P1, 12);
    hold(4'b0010, P2, 12);
    hold(4'b0100, P3, 12);
    hold(4'b1000, P4, 12);
    check("frame1_pulses", 32'(pulses - p0), 32'd1);
    check("frame1_bcd", 32'(if_cc.bcd_out), 32'h4321);
    check("frame1_err_blank", 32'({if_ca.err_out, if_ca.blank_out}), 32'h0);

    // Glitch on the completing digit
    hold(4'b0001, P0, 12);
    hold(4'b0010, P7, 12);
    hold(4'b1000, P9, 12);
    hold(4'b0100, P5, 5);
    hold(4'b0100, P6, 1);
    k = cyc + 1;
    hold(4'b0100, P5, 12);
    check("glitch_fv_edge", 32'(fv_edge), 32'(k + 9));
    check("glitch_digit2", 32'(if_ca.bcd_out[11:8]), 32'h5);
    check("glitch_bcd", 32'(if_ca.bcd_out), 32'h9570);

    // Blank, invalid and decimal point
    hold(4'b0001, PBLANK, 12);
    hold(4'b0010, PBAD, 12);
    hold(4'b0100, P2, 12);
    hold(4'b1000, P3 | 8'h01, 12);
    check("misc_bcd", 32'(if_cc.bcd_out), 32'h32EF);
    check("misc_blank", 32'(if_ca.blank_out), 32'b0001);
    check("misc_err", 32'(if_ca.err_out), 32'b0010);
    check("misc_dp", 32'(if_cc.dp_out), 32'b1000);

    // Multi-hot select mid-frame, then reordered scan
    p0 = pulses;
    hold(4'b1000, P8, 12);
    hold(4'b0011, P8, 20);
    check("multihot_no_frame", 32'(pulses - p0), 32'd0);
    hold(4'b0010, P6, 12);
    hold(4'b0001, P4, 12);
    hold(4'b0100, P1, 12);
    check("reorder_pulses", 32'(pulses - p0), 32'd1);
    check("reorder_bcd", 32'(if_ca.bcd_out), 32'h8164);

    // Reset mid-frame
    hold(4'b0001, P9, 12);
    hold(4'b0010, P9, 12);
    rst = 1'b1;
    hold(4'b0000, 8'h00, 2);
    check("midrst_bcd", 32'(if_ca.bcd_out), 32'h0);
    check("midrst_flags", 32'({if_cc.dp_out, if_cc.blank_out, if_cc.err_out, if_cc.frame_valid}), 32'h0);
    rst = 1'b0;
    p0 = pulses;
    hold(4'b0100, P2, 12);
    hold(4'b1000, P3, 12);
    check("midrst_partial", 32'(pulses - p0), 32'd0);
    check("midrst_partial_bcd", 32'(if_ca.bcd_out), 32'h0);
    hold(4'b0001, P0, 12);
    hold(4'b0010, P1, 12);
    check("midrst_frame", 32'(pulses - p0), 32'd1);
    check("midrst_bcd_new", 32'(if_ca.bcd_out), 32'h3210);

    // Alternate glyphs
    hold(4'b0001, A6, 12);
    hold(4'b0010, A7, 12);
    hold(4'b0100, A9, 12);
    hold(4'b1000, P5, 12);
`ifdef SEG2BCD_ALT_GLYPH_EN
    check("alt_bcd", 32'(if_ca.bcd_out), 32'h5976);
    check("alt_err", 32'(if_ca.err_out), 32'b0000);
`else
    check("alt_bcd", 32'(if_ca.bcd_out), 32'h5EEE);
    check("alt_err", 32'(if_ca.err_out), 32'b0111);
`endif
    hold(4'b0000, 8'h00, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
